// File: rtl/retire_ctrl.sv
// retire_ctrl: commit-stage controller behind the reorder buffer.
//
// Takes up to three retiring entries per cycle (slot 2 oldest). Counts the
// committed instructions, sends the oldest committed branch to the branch
// predictor, and on the oldest mispredicted entry runs precise-state recovery:
// a one-cycle recover pulse carrying the redirect PC, then a fixed drain window
// that stalls fetch and dispatch.
//
// Ports:
//   clock, reset            rising-edge clock, async active-low reset
//   retire_valid/...        per-slot retire info; pc/target are [2:0][XLEN-1:0]
//   recover_en, recover_pc  one-cycle recovery pulse and redirect PC
//   fetch_stall             high during drain
//   dispatch_stall          high during recover and drain
//   update_en/pc/direction/target  predictor update (values hold when idle)
//   commit_count            committed instructions, wraps
//   protocol_err            sticky: retire outside IDLE or non-contiguous valid

// Per-slot qualification. A slot commits when it is valid and no older valid
// slot mispredicted; the oldest mispredict itself still commits.
module retire_slot (
    input  logic valid,
    input  logic mispredict,
    input  logic is_branch,
    input  logic older_mp,
    output logic committed,
    output logic mp_hit,
    output logic br_hit
);
    assign committed = valid & ~older_mp;
    assign mp_hit    = committed & mispredict;
    assign br_hit    = committed & is_branch;
endmodule

module retire_ctrl #(
    parameter int XLEN         = 32,
    parameter int DRAIN_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [2:0]           retire_valid,
    input  logic [2:0]           retire_mispredict,
    input  logic [2:0]           retire_is_branch,
    input  logic [2:0]           retire_taken,
    input  logic [2:0][XLEN-1:0] retire_pc,
    input  logic [2:0][XLEN-1:0] retire_target,
    output logic                 recover_en,
    output logic [XLEN-1:0]      recover_pc,
    output logic                 fetch_stall,
    output logic                 dispatch_stall,
    output logic                 update_en,
    output logic [XLEN-1:0]      update_pc,
    output logic                 update_direction,
    output logic [XLEN-1:0]      update_target,
    output logic [CNT_W-1:0]     commit_count,
    output logic                 protocol_err
);
    localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, RECOVER, DRAIN} state_t;

    state_t         state;
    logic [DW-1:0]  drain_cnt;

    logic [2:0]     older_mp;
    logic [2:0]     committed;
    logic [2:0]     mp_hit;
    logic [2:0]     br_hit;

    // older_mp[i]: some valid slot older than i mispredicted.
    assign older_mp[2] = 1'b0;

    for (genvar i = 0; i < 3; i++) begin : g_slot
        if (i < 2) begin : g_chain
            assign older_mp[i] = older_mp[i+1] |
                                 (retire_valid[i+1] & retire_mispredict[i+1]);
        end
        retire_slot u_slot (
            .valid      (retire_valid[i]),
            .mispredict (retire_mispredict[i]),
            .is_branch  (retire_is_branch[i]),
            .older_mp   (older_mp[i]),
            .committed  (committed[i]),
            .mp_hit     (mp_hit[i]),
            .br_hit     (br_hit[i])
        );
    end

    logic [1:0]      pop;
    logic [XLEN-1:0] mp_target;
    logic [1:0]      br_sel;
    logic            noncontig;

    // Ascending scan so the highest (oldest) index wins the branch select.
    always_comb begin
        pop       = 2'd0;
        mp_target = '0;
        br_sel    = 2'd0;
        for (int i = 0; i < 3; i++) begin
            pop = pop + {1'b0, committed[i]};
            if (mp_hit[i]) mp_target = retire_target[i];
            if (br_hit[i]) br_sel = 2'(i);
        end
    end

    // Legal valid patterns fill from slot 2 downward: 000, 100, 110, 111.
    assign noncontig = (retire_valid == 3'b001) || (retire_valid == 3'b010) ||
                       (retire_valid == 3'b011) || (retire_valid == 3'b101);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            drain_cnt        <= '0;
            recover_en       <= 1'b0;
            recover_pc       <= '0;
            fetch_stall      <= 1'b0;
            dispatch_stall   <= 1'b0;
            update_en        <= 1'b0;
            update_pc        <= '0;
            update_direction <= 1'b0;
            update_target    <= '0;
            commit_count     <= '0;
            protocol_err     <= 1'b0;
        end else begin
            recover_en     <= 1'b0;
            update_en      <= 1'b0;
            fetch_stall    <= 1'b0;
            dispatch_stall <= 1'b0;

            if (noncontig || (state != IDLE && |retire_valid))
                protocol_err <= 1'b1;

            case (state)
                IDLE: begin
                    commit_count <= commit_count + CNT_W'(pop);
                    if (|br_hit) begin
                        update_en        <= 1'b1;
                        update_pc        <= retire_pc[br_sel];
                        update_direction <= retire_taken[br_sel];
                        update_target    <= retire_target[br_sel];
                    end
                    if (|mp_hit) begin
                        recover_en     <= 1'b1;
                        recover_pc     <= mp_target;
                        dispatch_stall <= 1'b1;
                        state          <= RECOVER;
                    end
                end
                RECOVER: begin
                    drain_cnt      <= DW'(DRAIN_CYCLES);
                    fetch_stall    <= 1'b1;
                    dispatch_stall <= 1'b1;
                    state          <= DRAIN;
                end
                DRAIN: begin
                    // Last drain cycle when the counter reads 1; stalls drop
                    // together with the return to IDLE.
                    if (drain_cnt == DW'(1)) begin
                        state <= IDLE;
                    end else begin
                        drain_cnt      <= drain_cnt - DW'(1);
                        fetch_stall    <= 1'b1;
                        dispatch_stall <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
